// File: rtl/cmp_sort_pkg.sv
// Shared definitions for the cmp_sort_ctrl bubble-sort controller.
// Holds the entry width, the FSM state encoding and the width helpers
// used to size index, count and statistics registers from N.
package cmp_sort_pkg;

   localparam int DATA_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SORT = 2'd1,
      FIN  = 2'd2
   } state_t;

   // Bits needed to address N entries (at least one bit).
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Bits needed to hold a fill count of 0..N.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

   // Bits needed to hold the worst-case swap total N*(N-1)/2.
   function automatic int swap_width(input int n);
      return $clog2((n * (n - 1)) / 2 + 1);
   endfunction

endpackage

// File: rtl/cmp_sort_twobit_gt.sv
// Two-bit unsigned greater-than comparator shared by the sort datapath.
module twobit_gt
   import cmp_sort_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              gt
);

   assign gt = (a > b);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// In-place bubble sort of N two-bit entries with load/start handshake.
// Optional feature: define CMP_SORT_STATS_EN to expose swap_count.
//
// state | meaning
// IDLE  | accept loads into buffer[count]; start accepted only when full
// SORT  | one compare (and possible swap) of buffer[i], buffer[i+1] per cycle
// FIN   | one-cycle done pulse, fill count cleared, buffer retained
module cmp_sort_ctrl
   import cmp_sort_pkg::*;
#(
   parameter int N = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      load_valid,
   input  logic [DATA_W-1:0]         load_data,
   output logic                      load_ready,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   input  logic [idx_width(N)-1:0]   rd_addr,
`ifdef CMP_SORT_STATS_EN
   output logic [swap_width(N)-1:0]  swap_count,
`endif
   output logic [DATA_W-1:0]         rd_data
);

   localparam int IDX_W = idx_width(N);
   localparam int CNT_W = cnt_width(N);
`ifdef CMP_SORT_STATS_EN
   localparam int SW_W  = swap_width(N);
`endif

   localparam logic [CNT_W-1:0] FULL      = CNT_W'(N);
   localparam logic [IDX_W-1:0] LAST_I    = IDX_W'(N - 2);
   localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);

   state_t              state;
   logic [DATA_W-1:0]   mem [N];
   logic [CNT_W-1:0]    count;
   logic [IDX_W-1:0]    idx;
   logic [IDX_W-1:0]    idx_nxt;
   logic [IDX_W-1:0]    pass_idx;
   logic                swapped;
   logic [DATA_W-1:0]   cmp_a;
   logic [DATA_W-1:0]   cmp_b;
   logic                gt;
   logic                pass_swapped;

   assign idx_nxt      = idx + IDX_W'(1);
   assign cmp_a        = mem[idx];
   assign cmp_b        = mem[idx_nxt];
   assign pass_swapped = swapped | gt;

   twobit_gt u_gt (
      .a  (cmp_a),
      .b  (cmp_b),
      .gt (gt)
   );

   // Loads are only possible in IDLE while the buffer still has room.
   assign load_ready = (state == IDLE) && (count < FULL);

   // Out-of-range addresses (non-power-of-two N) read as zero.
   assign rd_data = (int'(rd_addr) < N) ? mem[rd_addr] : '0;

   // Controller FSM, buffer updates and registered busy/done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         count    <= '0;
         idx      <= '0;
         pass_idx <= '0;
         swapped  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         for (int k = 0; k < N; k++) mem[k] <= '0;
`ifdef CMP_SORT_STATS_EN
         swap_count <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               // A load wins over start; start is only honoured once full.
               if (load_valid && load_ready) begin
                  mem[count[IDX_W-1:0]] <= load_data;
                  count                 <= count + CNT_W'(1);
               end else if (start && (count == FULL)) begin
                  state    <= SORT;
                  busy     <= 1'b1;
                  idx      <= '0;
                  pass_idx <= '0;
                  swapped  <= 1'b0;
`ifdef CMP_SORT_STATS_EN
                  swap_count <= '0;
`endif
               end
            end
            SORT: begin
               // Strict greater-than keeps equal entries in place (stable).
               if (gt) begin
                  mem[idx]     <= cmp_b;
                  mem[idx_nxt] <= cmp_a;
`ifdef CMP_SORT_STATS_EN
                  swap_count <= swap_count + SW_W'(1);
`endif
               end
               if (idx == LAST_I) begin
                  if (!pass_swapped || (pass_idx == LAST_PASS)) begin
                     state <= FIN;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     idx      <= '0;
                     pass_idx <= pass_idx + IDX_W'(1);
                     swapped  <= 1'b0;
                  end
               end else begin
                  idx     <= idx_nxt;
                  swapped <= pass_swapped;
               end
            end
            FIN: begin
               done  <= 1'b0;
               count <= '0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed self-checking bench for cmp_sort_ctrl with N = 4.
module tb_cmp_sort_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       load_valid = 1'b0;
   logic [1:0] load_data = '0;
   logic       load_ready;
   logic       start = 1'b0;
   logic       busy;
   logic       done;
   logic [1:0] rd_addr = '0;
   logic [1:0] rd_data;
`ifdef CMP_SORT_STATS_EN
   logic [2:0] swap_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cmp_sort_ctrl #(.N(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (load_ready),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .rd_addr    (rd_addr),
`ifdef CMP_SORT_STATS_EN
      .swap_count (swap_count),
`endif
      .rd_data    (rd_data)
   );

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      load_valid = 1'b0;
      start = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic load(input logic [1:0] v);
      load_valid = 1'b1;
      load_data  = v;
      step();
      load_valid = 1'b0;
   endtask

   task automatic peek(input int a, output logic [1:0] v);
      rd_addr = 2'(a);
      #1;
      v = rd_data;
   endtask

   // Loads four values, starts, and measures busy and done widths.
   task automatic run_sort(input logic [1:0] v0, input logic [1:0] v1,
                           input logic [1:0] v2, input logic [1:0] v3,
                           output int busy_cyc, output int done_cyc);
      busy_cyc = 0;
      done_cyc = 0;
      load(v0); load(v1); load(v2); load(v3);
      start = 1'b1;
      step();
      start = 1'b0;
      while (busy && busy_cyc < 100) begin
         busy_cyc++;
         step();
      end
      while (done && done_cyc < 100) begin
         done_cyc++;
         step();
      end
   endtask

   task automatic test_reset();
      logic [1:0] v;
      do_reset();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++;
      if (load_ready !== 1'b1) begin errors++; $display("FAIL reset_load_ready got %b want 1", load_ready); end
      for (int a = 0; a < 4; a++) begin
         peek(a, v);
         checks++;
         if (v !== 2'd0) begin errors++; $display("FAIL reset_mem[%0d] got %0d want 0", a, v); end
      end
   endtask

   task automatic test_sort_case(input string name,
                                 input logic [1:0] v0, input logic [1:0] v1,
                                 input logic [1:0] v2, input logic [1:0] v3,
                                 input logic [1:0] e0, input logic [1:0] e1,
                                 input logic [1:0] e2, input logic [1:0] e3,
                                 input int exp_busy, input int exp_swaps);
      int bc, dc;
      logic [1:0] v;
      logic [1:0] exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      do_reset();
      run_sort(v0, v1, v2, v3, bc, dc);
      checks++;
      if (bc !== exp_busy) begin errors++; $display("FAIL %s_busy_cycles got %0d want %0d", name, bc, exp_busy); end
      checks++;
      if (dc !== 1) begin errors++; $display("FAIL %s_done_cycles got %0d want 1", name, dc); end
      checks++;
      if (load_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_after got %b want 1", name, load_ready); end
      for (int a = 0; a < 4; a++) begin
         peek(a, v);
         checks++;
         if (v !== exp[a]) begin errors++; $display("FAIL %s_mem[%0d] got %0d want %0d", name, a, v, exp[a]); end
      end
`ifdef CMP_SORT_STATS_EN
      checks++;
      if (int'(swap_count) !== exp_swaps) begin errors++; $display("FAIL %s_swap_count got %0d want %0d", name, swap_count, exp_swaps); end
`else
      if (exp_swaps < 0) $display("note: negative swap expectation in %s", name);
`endif
   endtask

   // Reverse sort then partial reload: entries 0..1 overwritten, 2..3 kept.
   task automatic test_overwrite();
      int bc, dc;
      logic [1:0] v;
      do_reset();
      run_sort(2'd3, 2'd2, 2'd1, 2'd0, bc, dc);
      load(2'd3);
      load(2'd3);
      peek(0, v);
      checks++;
      if (v !== 2'd3) begin errors++; $display("FAIL overwrite_mem0 got %0d want 3", v); end
      peek(1, v);
      checks++;
      if (v !== 2'd3) begin errors++; $display("FAIL overwrite_mem1 got %0d want 3", v); end
      peek(2, v);
      checks++;
      if (v !== 2'd2) begin errors++; $display("FAIL overwrite_mem2 got %0d want 2", v); end
      peek(3, v);
      checks++;
      if (v !== 2'd3) begin errors++; $display("FAIL overwrite_mem3 got %0d want 3", v); end
   endtask

   task automatic test_handshake();
      int bc, dc;
      logic [1:0] v;
      do_reset();
      load(2'd2); load(2'd0); load(2'd1);
      // start with only three entries must be ignored
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_at_3_busy got %b want 0", busy); end
      checks++;
      if (load_ready !== 1'b1) begin errors++; $display("FAIL start_at_3_ready got %b want 1", load_ready); end
      // load and start together at count 3: load wins, no sort
      load_valid = 1'b1;
      load_data  = 2'd3;
      start      = 1'b1;
      step();
      load_valid = 1'b0;
      start      = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL load_start_busy got %b want 0", busy); end
      checks++;
      if (load_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", load_ready); end
      peek(3, v);
      checks++;
      if (v !== 2'd3) begin errors++; $display("FAIL load_start_mem3 got %0d want 3", v); end
      // fifth load while full must not disturb anything
      load(2'd0);
      peek(0, v);
      checks++;
      if (v !== 2'd2) begin errors++; $display("FAIL fifth_load_mem0 got %0d want 2", v); end
      peek(3, v);
      checks++;
      if (v !== 2'd3) begin errors++; $display("FAIL fifth_load_mem3 got %0d want 3", v); end
      // 2,0,1,3 sorts in two passes (two swaps in the first)
      start = 1'b1;
      step();
      start = 1'b0;
      bc = 0;
      while (busy && bc < 100) begin bc++; step(); end
      dc = 0;
      while (done && dc < 100) begin dc++; step(); end
      checks++;
      if (bc !== 6) begin errors++; $display("FAIL handshake_busy_cycles got %0d want 6", bc); end
      checks++;
      if (dc !== 1) begin errors++; $display("FAIL handshake_done_cycles got %0d want 1", dc); end
      for (int a = 0; a < 4; a++) begin
         peek(a, v);
         checks++;
         if (v !== 2'(a)) begin errors++; $display("FAIL handshake_mem[%0d] got %0d want %0d", a, v, a); end
      end
   endtask

   task automatic test_reset_mid_sort();
      logic [1:0] v;
      int seen_done;
      do_reset();
      load(2'd3); load(2'd2); load(2'd1); load(2'd0);
      start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before got %b want 1", busy); end
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++;
      if (load_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", load_ready); end
      for (int a = 0; a < 4; a++) begin
         peek(a, v);
         checks++;
         if (v !== 2'd0) begin errors++; $display("FAIL midrst_mem[%0d] got %0d want 0", a, v); end
      end
      seen_done = 0;
      for (int c = 0; c < 15; c++) begin
         if (done === 1'b1) seen_done++;
         step();
      end
      checks++;
      if (seen_done !== 0) begin errors++; $display("FAIL midrst_done_pulses got %0d want 0", seen_done); end
   endtask

   initial begin
      test_reset();
      test_sort_case("reverse", 2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 9, 6);
      test_sort_case("sorted",  2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 3, 0);
      test_sort_case("equal",   2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 3, 0);
      test_sort_case("mixed",   2'd1, 2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd3, 2'd3, 9, 2);
      test_overwrite();
      test_handshake();
      test_reset_mid_sort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cmp_sort_ctrl.md
CMP_SORT_CTRL -- requirements
Module: cmp_sort_ctrl

Interface
REQ-001 Parameter: N, default 4, number of 2-bit entries sorted (legal 2..16).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 load_valid  input  1  load_data is presented for write into the buffer.
REQ-005 load_data  input  2  unsigned value to load.
REQ-006 load_ready  output  1  buffer accepts a load this cycle.
REQ-007 start  input  1  request to sort the full buffer.
REQ-008 busy  output  1  high while in SORT.
REQ-009 done  output  1  one-cycle pulse when sorting completes.
REQ-010 rd_addr  input  clog2(N)  read index into the buffer.
REQ-011 rd_data  output  2  combinational read of buffer[rd_addr], valid in every state.

Function
REQ-012 The FSM SHALL have three states: IDLE, SORT, FIN.
- IDLE: load_ready = (count < N); a load is accepted when load_valid && load_ready, writing buffer[count] and incrementing count.
- IDLE -> SORT when start && count == N; start with count < N SHALL be ignored.
- SORT: one comparison per cycle at index i = 0..N-2, using the shared greater-than comparator on (buffer[i], buffer[i+1]).
  - If buffer[i] > buffer[i+1], the two entries SHALL be swapped in that cycle.
  - Equal values SHALL NOT swap, so the sort is stable.
- A pass is N-1 cycles. At the end of a pass, SORT -> FIN if that pass made no swap or N-1 passes are complete; otherwise a new pass starts at i = 0.
- FIN: lasts one cycle, done = 1, count cleared to 0, then -> IDLE. The sorted buffer SHALL be retained.
REQ-013 The result SHALL be ascending order: buffer[0] is smallest.
REQ-014 Latency from the start-accept edge to done SHALL be passes*(N-1) cycles plus 1 cycle in FIN.
- Best case (already sorted): N-1 sort cycles.
- Worst case (reverse order): (N-1)^2 sort cycles.
REQ-015 During SORT and FIN: load_ready = 0, load_valid is ignored, and start is ignored.
REQ-016 Same-cycle load and start in IDLE with count == N-1: the load SHALL be accepted and start SHALL be ignored.
REQ-017 Loads after FIN SHALL overwrite from index 0; unwritten entries SHALL keep their prior values.

Reset
REQ-018 On rst: state = IDLE, count = 0, i = 0, all buffer entries = 0, busy = 0, done = 0, load_ready = 1.
REQ-019 rst asserted mid-SORT SHALL abort the sort with the REQ-018 values next cycle, and no done pulse SHALL be issued.

Configuration
REQ-020 Macro CMP_SORT_STATS_EN controls a statistics output.
- Defined: adds output swap_count, width clog2(N*(N-1)/2+1). It is cleared on start-accept and on rst, incremented on every swap, and held after FIN until the next start.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Structure
REQ-021 Package cmp_sort_pkg SHALL hold:
- DATA_W = 2;
- the state encoding (IDLE = 0, SORT = 1, FIN = 2);
- the width helper constants.
REQ-022 The comparator SHALL be a sub-module instance of the existing twobit_gt; no inline duplicate of its logic is permitted.

Verification
REQ-023 Reverse order: load 3,2,1,0; start.
- busy for 9 cycles, then done pulse.
- rd_data at addr 0..3 = 0,1,2,3; swap_count = 6.
REQ-024 Already sorted: load 0,1,2,3; start.
- busy for 3 cycles, then done; contents unchanged; swap_count = 0.
REQ-025 Equal and mixed values:
- load 2,2,2,2 -> 3 cycles, no swaps.
- load 1,3,0,3 -> result 0,1,3,3.
REQ-026 Handshake limits:
- A 5th load_valid with load_ready = 0 SHALL NOT change the buffer.
- start at count = 3 SHALL be ignored (busy stays 0).
- Load+start in the same cycle at count = 3: load accepted, no sort.
REQ-027 Reset mid-sort: load 3,2,1,0, start, assert rst on the 4th SORT cycle.
- Next cycle: state IDLE, all entries 0, load_ready = 1.
- No done pulse SHALL appear.
